// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, sequencer states and operand/flag qualification helpers
package alu_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_SUBI = 6'b000011;
    localparam logic [5:0] OP_MUL  = 6'b000100;
    localparam logic [5:0] OP_MULI = 6'b000101;
    localparam logic [5:0] OP_DIV  = 6'b000110;
    localparam logic [5:0] OP_DIVI = 6'b000111;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_AND  = 6'b001011;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_OR   = 6'b001101;
    localparam logic [5:0] OP_ORI  = 6'b001110;
    localparam logic [5:0] OP_LDI  = 6'b010011;
    localparam logic [5:0] OP_BEQ  = 6'b010111;
    localparam logic [5:0] OP_BNE  = 6'b011000;
    localparam logic [5:0] OP_OUT  = 6'b011001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_DONE,
        ST_TRAP
    } state_t;

    // Immediate-form opcodes whose operand B is the sign-extended immediate
    function automatic logic is_imm_signed(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_MULI) ||
               (op == OP_DIVI) || (op == OP_SLTI) || (op == OP_LDI);
    endfunction

    // Logical immediates take the zero-extended immediate
    function automatic logic is_imm_zero(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    // Only real branches may forward the ALU branch flag (it idles high)
    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // Opcodes for which the ALU error flag is meaningful rather than stale
    function automatic logic err_qualified(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_MUL) ||
               (op == OP_MULI) || (op == OP_DIV) || (op == OP_DIVI);
    endfunction

    function automatic logic is_div(input logic [5:0] op);
        return (op == OP_DIV) || (op == OP_DIVI);
    endfunction

endpackage

// File: rtl/imm_extend.sv
// rtl/imm_extend.sv - immediate widening with sign or zero fill
module imm_extend #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] ext
);

    // Fill the upper bits with the immediate's sign bit or with zeros
    assign ext = sign_ext ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                          : {{(DATA_W-IMM_W){1'b0}}, imm};

endmodule

// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - execute-stage issue/capture sequencer around a combinational ALU
module alu_issue_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int PC_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_rt,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [PC_W-1:0]   in_pc,
    output logic [5:0]        alu_opCode,
    output logic [DATA_W-1:0] alu_dataA,
    output logic [DATA_W-1:0] alu_dataB,
    input  logic [DATA_W-1:0] alu_dataC,
    input  logic              alu_branch,
    input  logic              alu_error,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_branch,
    output logic [PC_W-1:0]   out_target,
    output logic              out_error,
    output logic              trap,
    input  logic              trap_clear
);

    state_t            state;
    logic [PC_W-1:0]   pc_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] imm_operand;
    logic [PC_W-1:0]   branch_offset;
    logic [DATA_W-1:0] operand_b;
    logic              div_zero;
    logic              err_hit;

    // Operand B immediate: sign-extended unless the opcode is a logical immediate
    imm_extend #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_operand_ext (
        .imm      (in_imm),
        .sign_ext (is_imm_signed(in_op)),
        .ext      (imm_operand)
    );

    // Branch offset is always signed and taken from the latched immediate
    imm_extend #(.IMM_W(IMM_W), .DATA_W(PC_W)) u_target_ext (
        .imm      (imm_q),
        .sign_ext (1'b1),
        .ext      (branch_offset)
    );

    // Select operand B from the immediate or the register file value
    always_comb begin
        operand_b = in_rt;
        if (is_imm_signed(in_op) || is_imm_zero(in_op)) begin
            operand_b = imm_operand;
        end
    end

    // Divide by zero is caught here so the result never depends on the ALU's choice
    assign div_zero = is_div(alu_opCode) && (alu_dataB == '0);
    assign err_hit  = (err_qualified(alu_opCode) && alu_error) || div_zero;

    assign in_ready = (state == ST_IDLE);

    // Sequencer FSM: issue operands, capture flags, hold result until consumed or trap cleared
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc_q       <= '0;
            imm_q      <= '0;
            alu_opCode <= '0;
            alu_dataA  <= '0;
            alu_dataB  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_branch <= 1'b0;
            out_target <= '0;
            out_error  <= 1'b0;
            trap       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        alu_opCode <= in_op;
                        alu_dataA  <= in_rs;
                        alu_dataB  <= operand_b;
                        pc_q       <= in_pc;
                        imm_q      <= in_imm;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    out_data   <= div_zero ? '0 : alu_dataC;
                    out_branch <= is_branch(alu_opCode) && alu_branch;
                    out_error  <= err_hit;
                    out_target <= pc_q + PC_W'(1) + branch_offset;
                    out_valid  <= 1'b1;
                    if (err_hit) begin
                        trap  <= 1'b1;
                        state <= ST_TRAP;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_TRAP: begin
                    if (trap_clear) begin
                        out_valid <= 1'b0;
                        trap      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb/tb_alu_issue_sequencer.sv - self-checking bench with behavioural ALU and reference model
module tb_alu_issue_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [15:0] in_imm;
    logic [31:0] in_pc;
    logic [5:0]  alu_opCode;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [31:0] alu_dataC;
    logic        alu_branch;
    logic        alu_error;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_branch;
    logic [31:0] out_target;
    logic        out_error;
    logic        trap;
    logic        trap_clear;
    logic [33:0] alu_resp;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_issue_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_imm     (in_imm),
        .in_pc      (in_pc),
        .alu_opCode (alu_opCode),
        .alu_dataA  (alu_dataA),
        .alu_dataB  (alu_dataB),
        .alu_dataC  (alu_dataC),
        .alu_branch (alu_branch),
        .alu_error  (alu_error),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_branch (out_branch),
        .out_target (out_target),
        .out_error  (out_error),
        .trap       (trap),
        .trap_clear (trap_clear)
    );

    // Behavioural ALU: returns {error, branch, result}; flags idle high when not meaningful
    function automatic logic [33:0] alu_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] c;
        logic        br;
        logic        er;
        longint      p;
        c  = a ^ b;
        br = 1'b1;
        er = 1'b1;
        case (op)
            6'd0, 6'd1: begin
                c  = a + b;
                er = (a[31] == b[31]) && (c[31] != a[31]);
            end
            6'd2, 6'd3: c = a - b;
            6'd4, 6'd5: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                c  = p[31:0];
                er = (p != longint'($signed(p[31:0])));
            end
            6'd6, 6'd7: begin
                if (b == 32'd0) begin
                    c  = 32'hDEADBEEF;
                    er = 1'b0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    c  = a;
                    er = 1'b1;
                end else begin
                    c  = 32'($signed(a) / $signed(b));
                    er = 1'b0;
                end
            end
            6'd11, 6'd12: c = a & b;
            6'd13, 6'd14: c = a | b;
            6'd23: begin
                c  = a - b;
                br = (a == b);
            end
            6'd24: begin
                c  = a - b;
                br = (a != b);
            end
            default: ;
        endcase
        return {er, br, c};
    endfunction

    always_comb alu_resp = alu_model(alu_opCode, alu_dataA, alu_dataB);
    assign alu_error  = alu_resp[33];
    assign alu_branch = alu_resp[32];
    assign alu_dataC  = alu_resp[31:0];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        in_op  = 6'($urandom);
        in_rs  = $urandom;
        in_rt  = $urandom;
        in_imm = 16'($urandom);
        in_pc  = $urandom;
    endtask

    // One instruction from the IDLE negedge through handshake; ends at the next IDLE negedge
    task automatic run_instr(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [15:0] imm, input logic [31:0] pc, input int hold);
        logic [31:0] exp_b;
        logic [33:0] m;
        logic        qual;
        logic        divz;
        logic        exp_err;
        logic        exp_br;
        logic [31:0] exp_data;
        logic [31:0] exp_tgt;

        if (op inside {6'd1, 6'd3, 6'd5, 6'd7, 6'd10, 6'd19}) exp_b = {{16{imm[15]}}, imm};
        else if (op inside {6'd12, 6'd14})                    exp_b = {16'h0000, imm};
        else                                                   exp_b = rt;
        m        = alu_model(op, rs, exp_b);
        qual     = op inside {6'd0, 6'd1, 6'd4, 6'd5, 6'd6, 6'd7};
        divz     = (op inside {6'd6, 6'd7}) && (exp_b == 32'd0);
        exp_err  = (qual && m[33]) || divz;
        exp_data = divz ? 32'd0 : m[31:0];
        exp_br   = (op == 6'd23) ? (rs == exp_b) : (op == 6'd24) ? (rs != exp_b) : 1'b0;
        exp_tgt  = pc + 32'd1 + {{16{imm[15]}}, imm};

        chk1("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_op = op; in_rs = rs; in_rt = rt; in_imm = imm; in_pc = pc;
        @(negedge clock);
        in_valid = 1'b0;
        scramble_inputs();
        chk1("in_ready_issue", in_ready, 1'b0);
        chk1("out_valid_issue", out_valid, 1'b0);
        chk32("alu_opCode", 32'(alu_opCode), 32'(op));
        chk32("alu_dataA", alu_dataA, rs);
        chk32("alu_dataB", alu_dataB, exp_b);
        @(negedge clock);
        in_valid = 1'b1;
        chk1("out_valid_capture", out_valid, 1'b0);
        chk32("alu_dataB_hold", alu_dataB, exp_b);
        @(negedge clock);
        chk1("out_valid", out_valid, 1'b1);
        chk32("out_data", out_data, exp_data);
        chk1("out_branch", out_branch, exp_br);
        chk1("out_error", out_error, exp_err);
        chk32("out_target", out_target, exp_tgt);
        chk1("trap", trap, exp_err);
        if (exp_err) begin
            out_ready = 1'b1;
            repeat (2) begin
                @(negedge clock);
                chk1("trap_valid_hold", out_valid, 1'b1);
                chk1("trap_hold", trap, 1'b1);
                chk32("trap_data_hold", out_data, exp_data);
            end
            out_ready  = 1'b0;
            trap_clear = 1'b1;
            @(negedge clock);
            trap_clear = 1'b0;
            in_valid   = 1'b0;
            chk1("trap_clear_valid", out_valid, 1'b0);
            chk1("trap_clear_trap", trap, 1'b0);
            chk1("trap_clear_ready", in_ready, 1'b1);
        end else begin
            for (int i = 0; i < hold; i++) begin
                trap_clear = 1'($urandom_range(0, 1));
                @(negedge clock);
                chk1("bp_valid", out_valid, 1'b1);
                chk32("bp_data", out_data, exp_data);
                chk32("bp_target", out_target, exp_tgt);
                chk1("bp_branch", out_branch, exp_br);
                chk1("bp_in_ready", in_ready, 1'b0);
            end
            trap_clear = 1'b0;
            out_ready  = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
            in_valid  = 1'b0;
            chk1("done_valid", out_valid, 1'b0);
            chk1("done_ready", in_ready, 1'b1);
        end
    endtask

    logic [5:0] op_tab [0:15];
    logic [5:0] r_op;
    logic [31:0] r_rs;
    logic [31:0] r_rt;

    initial begin
        op_tab = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                   6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd19, 6'd23, 6'd24};
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; trap_clear = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_imm = '0; in_pc = '0;
        repeat (2) @(negedge clock);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_out_data", out_data, 32'd0);
        chk32("rst_out_target", out_target, 32'd0);
        chk1("rst_trap", trap, 1'b0);
        chk32("rst_alu_dataB", alu_dataB, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_instr(6'd0,  32'd5,  32'd7, 16'h0000, 32'd0,   0);
        run_instr(6'd3,  32'd10, 32'd0, 16'hFFFF, 32'd4,   0);
        run_instr(6'd12, 32'd10, 32'd0, 16'hFFFF, 32'd8,   1);
        run_instr(6'd23, 32'd3,  32'd3, 16'hFFFC, 32'd100, 0);
        run_instr(6'd24, 32'd3,  32'd3, 16'hFFFC, 32'd100, 0);
        run_instr(6'd11, 32'd3,  32'd3, 16'h0000, 32'd12,  0);
        run_instr(6'd6,  32'd9,  32'd0, 16'h0000, 32'd16,  0);
        run_instr(6'd1,  32'h7FFF_FFFF, 32'd0, 16'h0001, 32'd20, 0);
        run_instr(6'd2,  32'h8000_0000, 32'd1, 16'h0000, 32'hFFFF_FFFF, 5);

        // Reset while the instruction sits in ISSUE: it must vanish without a result
        in_valid = 1'b1; in_op = 6'd0; in_rs = 32'd1; in_rt = 32'd2; in_imm = 16'd0; in_pc = 32'd0;
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk1("mid_rst_valid", out_valid, 1'b0);
        chk1("mid_rst_ready", in_ready, 1'b1);
        chk32("mid_rst_alu_a", alu_dataA, 32'd0);
        chk32("mid_rst_alu_op", 32'(alu_opCode), 32'd0);
        chk32("mid_rst_data", out_data, 32'd0);
        repeat (5) begin
            @(negedge clock);
            chk1("mid_rst_no_valid", out_valid, 1'b0);
        end

        for (int n = 0; n < 150; n++) begin
            r_op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 15)];
            r_rs = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 3))
                0:       r_rt = 32'd0;
                1:       r_rt = r_rs;
                2:       r_rt = 32'($urandom_range(0, 20));
                default: r_rt = $urandom;
            endcase
            run_instr(r_op, r_rs, r_rt, 16'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
